seg_scan4: RTL and testbench
============================

# seg_scan4

Four-digit multiplexed scanner for the board's common-anode 7-segment display. It sits directly downstream of the counting/control logic and drives the physical LED segment and SA digit-select pins. It holds a double-buffered hex value per digit and time-multiplexes the digits at a fixed scan rate. Each digit slot begins with anti-ghosting blanking. New digit data is written to a shadow buffer and becomes visible atomically at the next frame boundary, under a COMMIT/ACK handshake.

## Interface
- SCAN_DIV, 50000: clock cycles per digit slot (≥ GUARD+1, ≥ 2)
- GUARD, 2: blanking cycles at the start of each slot (≥ 0)
- CNT_W, 16: width of the slot counter (2^CNT_W ≥ SCAN_DIV)

- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  synchronous reset, active-high
- LD  in  1  write strobe into the shadow buffer, one cycle per write
- DIGIT_SEL  in  2  shadow entry written by LD (0 = rightmost, SA[0])
- VAL  in  4  hex value 0–F for that entry
- DP  in  1  decimal point on (1) for that entry
- EN  in  1  digit enabled (0 = digit shows blank)
- COMMIT  in  1  request to copy shadow into active at the next frame boundary
- BUSY  out  1  commit pending
- ACK  out  1  one-cycle pulse on the cycle the copy occurs
- LED  out  8  segments {a,b,c,d,e,f,g,dp}, active-low (LED[7]=a, LED[0]=dp)
- SA  out  4  digit selects, active-low, at most one low

## Operation
- Storage: shadow and active sets, each 4 × {VAL[3:0], DP, EN}.
- LD writes shadow[DIGIT_SEL] <= {VAL, DP, EN}. LD is never ignored. Active is never written by LD.
- Scan: slot counter cnt runs 0..SCAN_DIV-1. Digit index dig (0..3) increments on cnt==SCAN_DIV-1 and wraps 3→0.
- Frame boundary: the cycle with cnt==SCAN_DIV-1 and dig==3.
- Commit handshake:
  - COMMIT sets pending (BUSY=1).
  - At a frame boundary with pending=1: active <= shadow (pre-edge contents), ACK=1 for one cycle, pending cleared.
  - COMMIT while pending=1 has no effect.
  - COMMIT in the same cycle as a boundary with pending=0 sets pending. The copy then occurs at the following boundary.
  - LD in the copy cycle updates shadow only. The active set receives the old value.
- Output selection for the current slot:
  - If cnt < GUARD, or active[dig].EN==0: SA=1111, LED=8'hFF.
  - Otherwise SA has only bit dig low (dig0 → 1110, dig3 → 0111), LED[7:1]=seg(active[dig].VAL), LED[0]=~active[dig].DP.
- seg() is active-low abcdefg:
  - 0:0000001, 1:1001111, 2:0010010, 3:0000110
  - 4:1001100, 5:0100100, 6:0100000, 7:0001111
  - 8:0000000, 9:0000100, A:0001000, b:1100000
  - C:0110001, d:1000010, E:0110000, F:0111000
- Reset values:
  - cnt=0, dig=0, pending=0.
  - Shadow and active all zero, so EN=0 and every digit is blank.
  - BUSY=0, ACK=0, SA=4'b1111, LED=8'hFF.
- Reset mid-operation (including with a commit pending): all state returns to the reset values, the pending commit is dropped, and no ACK is produced.

## Timing
- LED, SA, ACK and BUSY are registered outputs.
- LED/SA reflect the cnt/dig/active values of the previous cycle (1-cycle latency).
- Each slot lasts SCAN_DIV cycles. The output is blank for GUARD of those cycles and drives the digit for SCAN_DIV-GUARD. A frame lasts 4·SCAN_DIV cycles.
- First output after RST deasserts: the cycle after the first non-reset edge, with SA=1111 (guard of dig 0).
- BUSY rises the cycle after COMMIT is sampled. It falls in the same cycle ACK rises.
- Commit latency is ≤ 4·SCAN_DIV+1 cycles from COMMIT to ACK.
- New digit content becomes visible starting with the first dig-0 slot after ACK. There is never a partially updated frame.
- SA never has more than one low bit. During a digit change SA always passes through 1111 when GUARD ≥ 1.

## Test plan
(SCAN_DIV=8, GUARD=2 throughout.)
- Reset:
  - Stimulus: hold RST 3 cycles, release, run 64 cycles with no writes.
  - Required response: SA=1111, LED=FF, BUSY=0 and ACK=0 throughout.
- Basic load/commit:
  - Stimulus: LD digits 0..3 = 1,2,3,4 with EN=1, DP=0 on digit 0 and DP=1 on digit 2, then COMMIT.
  - Required response: BUSY=1 next cycle. ACK pulses exactly once at the dig3→0 boundary. The next frame shows SA=1110/LED=9F, SA=1101/LED=25, SA=1011/LED=0C, SA=0111/LED=99, each for 6 cycles after 2 blank cycles.
- Atomicity:
  - Stimulus: with "1234" active, LD digit 0 = 8 without COMMIT.
  - Required response: the display stays "1234" for 3 frames. After COMMIT+ACK, digit 0 shows LED=01.
- Collision:
  - Stimulus: assert LD (digit 1 = F) in the exact copy cycle.
  - Required response: active digit 1 keeps its old value. The next COMMIT shows LED=71 on SA=1101.
- Repeated COMMIT and blanking:
  - Stimulus: pulse COMMIT 3 times within one frame. Separately, set EN=0 on digit 2.
  - Required response: a single ACK for the three pulses. The digit-2 slot stays at SA=1111/LED=FF.
- Mid-operation reset:
  - Stimulus: assert RST while BUSY=1 in the middle of a slot.
  - Required response: outputs return to reset values, no ACK pulse, and the display stays blank afterwards.

Source files
------------

// File: rtl/seg_scan4.sv
// seg_scan4: four-digit multiplexed scanner for a common-anode 7-segment
// display. Shadow/active digit buffers with an atomic frame-boundary commit,
// per-slot anti-ghosting blanking, and registered LED/SA/ACK/BUSY outputs.
module seg_scan4 #(
  parameter int SCAN_DIV = 50000,  // clock cycles per digit slot
  parameter int GUARD    = 2,      // blanking cycles at the start of a slot
  parameter int CNT_W    = 16      // slot counter width
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LD,
  input  logic [1:0] DIGIT_SEL,
  input  logic [3:0] VAL,
  input  logic       DP,
  input  logic       EN,
  input  logic       COMMIT,
  output logic       BUSY,
  output logic       ACK,
  output logic [7:0] LED,
  output logic [3:0] SA
);

  typedef struct packed {
    logic [3:0] val;
    logic       dp;
    logic       en;
  } digit_t;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dig_q, dig_d;
  logic             pending_q, pending_d;
  logic             ack_q, ack_d;
  logic [7:0]       led_q, led_d;
  logic [3:0]       sa_q, sa_d;
  digit_t [3:0]     shadow_q, shadow_d;
  digit_t [3:0]     active_q, active_d;

  logic             slot_end;
  logic             frame_end;
  digit_t           cur;

  // Active-low abcdefg pattern for a hex value.
  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
  endfunction

  // Next-state: scan counters, commit handshake, shadow writes, output decode.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    cnt_d     = cnt_q;
    dig_d     = dig_q;
    pending_d = pending_q;
    ack_d     = 1'b0;
    shadow_d  = shadow_q;
    active_d  = active_q;
    sa_d      = 4'b1111;
    led_d     = 8'hFF;

    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (dig_q == 2'd3);

    if (slot_end) begin
      cnt_d = '0;
      dig_d = dig_q + 2'd1;  // 2-bit index wraps 3 -> 0 by itself
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // The copy takes the pre-edge shadow, so an LD in the same cycle only
    // lands in the shadow and waits for the next commit.
    if (frame_end && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
      ack_d     = 1'b1;
    end else if (COMMIT) begin
      pending_d = 1'b1;
    end

    if (LD) begin
      shadow_d[DIGIT_SEL] = '{val: VAL, dp: DP, en: EN};
    end

    cur = active_q[dig_q];
    if ((cnt_q >= CNT_GUARD) && cur.en) begin
      sa_d  = ~(4'b0001 << dig_q);
      led_d = {seg(cur.val), ~cur.dp};
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q     <= '0;
      dig_q     <= '0;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
      sa_q      <= 4'b1111;
      led_q     <= 8'hFF;
      // NOTE: the digit buffers are reset because a cleared EN is what
      // keeps every digit blank until the first commit.
      shadow_q  <= '0;
      active_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      cnt_q     <= cnt_d;
      dig_q     <= dig_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
      sa_q      <= sa_d;
      led_q     <= led_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
    end
  end

  assign BUSY = pending_q;
  assign ACK  = ack_q;
  assign LED  = led_q;
  assign SA   = sa_q;

endmodule

// File: tb/tb_seg_scan4.sv
// tb_seg_scan4: cycle scoreboard against a reference model, a hex-decode
// vector table, and hand-written sequences for commit/collision/reset cases.
module tb_seg_scan4;

  localparam int SD = 8;
  localparam int G  = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       LD = 1'b0;
  logic [1:0] DIGIT_SEL = '0;
  logic [3:0] VAL = '0;
  logic       DP = 1'b0;
  logic       EN = 1'b0;
  logic       COMMIT = 1'b0;
  logic       BUSY;
  logic       ACK;
  logic [7:0] LED;
  logic [3:0] SA;

  seg_scan4 #(.SCAN_DIV(SD), .GUARD(G), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .LD(LD), .DIGIT_SEL(DIGIT_SEL), .VAL(VAL),
    .DP(DP), .EN(EN), .COMMIT(COMMIT), .BUSY(BUSY), .ACK(ACK),
    .LED(LED), .SA(SA)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  int ack_cnt = 0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  function automatic logic [6:0] seg_ref(input logic [3:0] v);
    case (v)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  int         m_cnt = 0;
  int         m_dig = 0;
  bit         m_pend = 1'b0;
  logic [5:0] m_sh[4];   // {val, dp, en}
  logic [5:0] m_ac[4];
  logic [13:0] sb_q[$];  // {sa, led, busy, ack}

  initial begin
    logic       bnd, e_ack;
    logic [3:0] e_sa, onehot;
    logic [7:0] e_led;
    logic [5:0] cur;
    for (int k = 0; k < 4; k++) begin m_sh[k] = '0; m_ac[k] = '0; end
    forever begin
      @(posedge CLK);
      if (RST) begin
        m_cnt = 0; m_dig = 0; m_pend = 1'b0;
        for (int k = 0; k < 4; k++) begin m_sh[k] = '0; m_ac[k] = '0; end
        sb_q.push_back({4'hF, 8'hFF, 1'b0, 1'b0});
      end else begin
        bnd = (m_cnt == SD - 1) && (m_dig == 3);
        cur = m_ac[m_dig];
        if (m_cnt < G || !cur[0]) begin
          e_sa = 4'hF; e_led = 8'hFF;
        end else begin
          onehot = 4'b0001 << m_dig;
          e_sa = ~onehot;
          e_led = {seg_ref(cur[5:2]), ~cur[1]};
        end
        e_ack = bnd && m_pend;
        if (e_ack) begin
          for (int k = 0; k < 4; k++) m_ac[k] = m_sh[k];
          m_pend = 1'b0;
        end else if (COMMIT) begin
          m_pend = 1'b1;
        end
        if (LD) m_sh[DIGIT_SEL] = {VAL, DP, EN};
        if (m_cnt == SD - 1) begin m_cnt = 0; m_dig = (m_dig + 1) % 4; end
        else m_cnt++;
        sb_q.push_back({e_sa, e_led, m_pend, e_ack});
      end
    end
  end

  // Pop one expected record per cycle and compare away from the clock edge.
  initial begin
    logic [13:0] e;
    forever begin
      @(negedge CLK);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("sb", {SA, LED, BUSY, ACK}, e);
      end
    end
  end

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (ACK) ack_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic ld(input logic [1:0] d, input logic [3:0] v,
                    input logic p, input logic e);
    @(negedge CLK);
    LD = 1'b1; DIGIT_SEL = d; VAL = v; DP = p; EN = e;
    @(negedge CLK);
    LD = 1'b0;
  endtask

  task automatic commit_pulse();
    @(negedge CLK);
    COMMIT = 1'b1;
    @(negedge CLK);
    COMMIT = 1'b0;
  endtask

  task automatic wait_ack(input string name);
    logic seen = 1'b0;
    for (int i = 0; i < 4 * SD + 8 && !seen; i++) begin
      @(negedge CLK);
      if (ACK) seen = 1'b1;
    end
    check(name, seen, 1'b1);
  endtask

  // Leave off at a negedge where the next sampled output is the dig-0 guard.
  task automatic align(input string name);
    logic ok = 1'b0;
    for (int i = 0; i < 4 * SD + 2 && !ok; i++) begin
      if (m_cnt == 0 && m_dig == 0) ok = 1'b1;
      else @(negedge CLK);
    end
    check(name, ok, 1'b1);
  endtask

  // Check one whole frame: leds = {l3,l2,l1,l0}, en = per-digit enable.
  task automatic check_frame(input string name, input logic [31:0] leds,
                             input logic [3:0] en);
    logic [3:0] onehot, exp_sa;
    logic [7:0] exp_led;
    int errs;
    for (int s = 0; s < 4; s++) begin
      errs = 0;
      for (int c = 0; c < SD; c++) begin
        @(negedge CLK);
        if (c < G || !en[s]) begin
          exp_sa = 4'hF; exp_led = 8'hFF;
        end else begin
          onehot = 4'b0001 << s;
          exp_sa = ~onehot;
          exp_led = leds[8*s +: 8];
        end
        if (SA !== exp_sa || LED !== exp_led) errs++;
      end
      check($sformatf("%s_d%0d_bad_cycles", name, s), errs, 0);
    end
  endtask

  typedef struct {
    logic [3:0] val;
    logic       dp;
    logic [7:0] led;
  } vec_t;

  vec_t vecs[16];

  // ---------------- test sequence ----------------
  initial begin
    int base, bad;
    logic found;

    vecs[0]  = '{4'h0, 1'b0, 8'h03};  vecs[1]  = '{4'h1, 1'b1, 8'h9E};
    vecs[2]  = '{4'h2, 1'b0, 8'h25};  vecs[3]  = '{4'h3, 1'b1, 8'h0C};
    vecs[4]  = '{4'h4, 1'b0, 8'h99};  vecs[5]  = '{4'h5, 1'b1, 8'h48};
    vecs[6]  = '{4'h6, 1'b0, 8'h41};  vecs[7]  = '{4'h7, 1'b1, 8'h1E};
    vecs[8]  = '{4'h8, 1'b0, 8'h01};  vecs[9]  = '{4'h9, 1'b1, 8'h08};
    vecs[10] = '{4'hA, 1'b0, 8'h11};  vecs[11] = '{4'hB, 1'b1, 8'hC0};
    vecs[12] = '{4'hC, 1'b0, 8'h63};  vecs[13] = '{4'hD, 1'b1, 8'h84};
    vecs[14] = '{4'hE, 1'b0, 8'h61};  vecs[15] = '{4'hF, 1'b1, 8'h70};

    // Reset: 3 cycles, then 64 idle cycles fully blank.
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    bad = 0;
    repeat (64) begin
      @(negedge CLK);
      if (SA !== 4'hF || LED !== 8'hFF || BUSY !== 1'b0 || ACK !== 1'b0) bad++;
    end
    check("reset_idle_bad_cycles", bad, 0);

    // Basic load/commit: "1234", DP on digit 2.
    ld(2'd0, 4'h1, 1'b0, 1'b1);
    ld(2'd1, 4'h2, 1'b0, 1'b1);
    ld(2'd2, 4'h3, 1'b1, 1'b1);
    ld(2'd3, 4'h4, 1'b0, 1'b1);
    base = ack_cnt;
    commit_pulse();
    check("busy_after_commit", BUSY, 1'b1);
    wait_ack("basic_ack");
    check("busy_falls_with_ack", BUSY, 1'b0);
    check_frame("basic", {8'h99, 8'h0C, 8'h25, 8'h9F}, 4'hF);
    check("basic_ack_once", ack_cnt - base, 1);

    // Atomicity: shadow write without commit is invisible for 3 frames.
    ld(2'd0, 4'h8, 1'b0, 1'b1);
    align("atom_align");
    base = ack_cnt;
    repeat (3) check_frame("atom_hold", {8'h99, 8'h0C, 8'h25, 8'h9F}, 4'hF);
    check("atom_no_ack", ack_cnt - base, 0);
    commit_pulse();
    wait_ack("atom_ack");
    check_frame("atom_new", {8'h99, 8'h0C, 8'h25, 8'h01}, 4'hF);

    // Collision: LD digit 1 = F in the exact copy cycle.
    commit_pulse();
    found = 1'b0;
    for (int i = 0; i < 4 * SD + 4 && !found; i++) begin
      if (m_cnt == SD - 1 && m_dig == 3 && m_pend) found = 1'b1;
      else @(negedge CLK);
    end
    check("coll_find_boundary", found, 1'b1);
    LD = 1'b1; DIGIT_SEL = 2'd1; VAL = 4'hF; DP = 1'b0; EN = 1'b1;
    @(negedge CLK);
    LD = 1'b0;
    check("coll_ack", ACK, 1'b1);
    check_frame("coll_old", {8'h99, 8'h0C, 8'h25, 8'h01}, 4'hF);
    commit_pulse();
    wait_ack("coll_ack2");
    check_frame("coll_new", {8'h99, 8'h0C, 8'h71, 8'h01}, 4'hF);

    // Repeated COMMIT within one frame plus a disabled digit 2.
    ld(2'd2, 4'h3, 1'b1, 1'b0);
    align("rep_align");
    base = ack_cnt;
    commit_pulse();
    repeat (4) @(negedge CLK);
    commit_pulse();
    repeat (4) @(negedge CLK);
    commit_pulse();
    wait_ack("rep_ack");
    check_frame("rep_blank2", {8'h99, 8'hFF, 8'h71, 8'h01}, 4'b1011);
    check("rep_single_ack", ack_cnt - base, 1);

    // Mid-operation reset with a commit pending.
    align("mrst_align");
    repeat (3) @(negedge CLK);
    commit_pulse();
    repeat (2) @(negedge CLK);
    check("mrst_busy_before", BUSY, 1'b1);
    base = ack_cnt;
    RST = 1'b1;
    bad = 0;
    repeat (2) begin
      @(negedge CLK);
      if (SA !== 4'hF || LED !== 8'hFF || BUSY !== 1'b0 || ACK !== 1'b0) bad++;
    end
    RST = 1'b0;
    repeat (5 * SD) begin
      @(negedge CLK);
      if (SA !== 4'hF || LED !== 8'hFF || BUSY !== 1'b0 || ACK !== 1'b0) bad++;
    end
    check("mrst_blank_bad_cycles", bad, 0);
    check("mrst_no_ack", ack_cnt - base, 0);

    // Hex decode table through digit 0.
    for (int i = 0; i < 16; i++) begin
      ld(2'd0, vecs[i].val, vecs[i].dp, 1'b1);
      commit_pulse();
      wait_ack($sformatf("tab%0d_ack", i));
      repeat (G + 1) @(negedge CLK);
      check($sformatf("tab%0d_sa", i), SA, 4'b1110);
      check($sformatf("tab%0d_led", i), LED, vecs[i].led);
    end

    @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want done");
    $fatal(1, "watchdog");
  end

endmodule
